// File: rtl/keypad_pkg.sv
// Shared keypad constants and helpers.
// Used by the scanner top and its frame debouncer.
package keypad_pkg;

  localparam int KEY_MAXW = 64;

  localparam logic [KEY_MAXW-1:0] KEY_NONE_COL = '1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic popcnt_ge2(
    input logic [KEY_MAXW-1:0] v
  );
    return (v & (v - 64'd1)) != '0;
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-frame debouncer: a frame must repeat DEBOUNCE
// times in a row before it becomes the committed key map.
import keypad_pkg::*;

module keypad_frame_debounce #(
  parameter int N        = 20,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] frame_i,
  input  logic         frame_done_i,
  output logic [N-1:0] key_map_o,
  output logic         commit_o
);

  localparam int SW = $clog2(DEBOUNCE + 1);

  logic [N-1:0]  prev_q;
  logic [N-1:0]  map_q;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          commit_q;

  always_comb begin
    cnt_d = cnt_q;
    if (frame_i != prev_q)
      cnt_d = SW'(1);
    else if (cnt_q != SW'(DEBOUNCE))
      cnt_d = cnt_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q   <= '0;
      cnt_q    <= '0;
      map_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (frame_done_i) begin
        prev_q <= frame_i;
        cnt_q  <= cnt_d;
        if (cnt_d == SW'(DEBOUNCE)) begin
          map_q    <= frame_i;
          commit_q <= 1'b1;
        end
      end
    end
  end

  assign key_map_o = map_q;
  assign commit_o  = commit_q;

endmodule

// File: rtl/keypad_scan_gen.sv
// Matrix keypad scanner: one-cold column strobes, synced
// active-low rows, frame debounce, press/release/code encoder.
import keypad_pkg::*;

module keypad_scan_gen #(
  parameter int N_COL    = 4,
  parameter int N_ROW    = 5,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  localparam int NK      = N_ROW * N_COL,
  localparam int CW      = idx_width(NK)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_ROW-1:0] key_row,
  output logic [N_COL-1:0] key_col,
  output logic [NK-1:0]    key_map,
  output logic [CW-1:0]    key_code,
  output logic             key_press,
  output logic             key_release,
  output logic             key_multi
);

  localparam int CI = idx_width(N_COL);
  localparam int DI = idx_width(SCAN_DIV);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_COL  = 1'b1;

  logic [N_ROW-1:0] row_s1_q, row_s2_q;
  logic [0:0]       state_q, state_d;
  logic [CI-1:0]    col_q, col_d;
  logic [DI-1:0]    dwell_q, dwell_d;
  logic [N_COL-1:0] key_col_q, key_col_d;
  logic [NK-1:0]    frame_q;
  logic             frame_done_q;
  logic             sample;

  logic [NK-1:0]    map_w, map_prev_q;
  logic             commit_w;
  logic [CW-1:0]    code_q, code_d;
  logic             press_q, release_q, multi_q;
  logic             zero_old, zero_new, one_new;

  assign sample = (state_q == ST_COL) &&
                  (dwell_q == DI'(SCAN_DIV - 1));

  always_comb begin
    state_d = ST_COL;
    col_d   = col_q;
    dwell_d = dwell_q + DI'(1);
    if (state_q == ST_IDLE) begin
      col_d   = '0;
      dwell_d = '0;
    end else if (sample) begin
      dwell_d = '0;
      col_d   = (col_q == CI'(N_COL - 1)) ?
                '0 : col_q + CI'(1);
    end
    key_col_d = ~(N_COL'(1) << col_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_s1_q     <= '0;
      row_s2_q     <= '0;
      state_q      <= ST_IDLE;
      col_q        <= '0;
      dwell_q      <= '0;
      key_col_q    <= KEY_NONE_COL[N_COL-1:0];
      frame_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_s1_q     <= key_row;
      row_s2_q     <= row_s1_q;
      state_q      <= state_d;
      col_q        <= col_d;
      dwell_q      <= dwell_d;
      key_col_q    <= key_col_d;
      frame_done_q <= sample &&
                      (col_q == CI'(N_COL - 1));
      if (sample)
        frame_q[col_q*N_ROW +: N_ROW] <= ~row_s2_q;
    end
  end

  keypad_frame_debounce #(
    .N        (NK),
    .DEBOUNCE (DEBOUNCE)
  ) u_deb (
    .clk          (clk),
    .rstn         (rstn),
    .frame_i      (frame_q),
    .frame_done_i (frame_done_q),
    .key_map_o    (map_w),
    .commit_o     (commit_w)
  );

  assign zero_old = (map_prev_q == '0);
  assign zero_new = (map_w == '0);
  assign one_new  = !zero_new &&
                    !popcnt_ge2(KEY_MAXW'(map_w));

  always_comb begin
    code_d = '0;
    for (int i = 0; i < NK; i++)
      if (map_w[i]) code_d = CW'(i);
  end

  // map_prev_q lags map_w by one cycle, so in the
  // commit cycle it still holds the pre-commit map
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      map_prev_q <= '0;
      code_q     <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      map_prev_q <= map_w;
      press_q    <= commit_w && zero_old && one_new;
      release_q  <= commit_w && !zero_old && zero_new;
      multi_q    <= popcnt_ge2(KEY_MAXW'(map_w));
      if (commit_w && zero_old && one_new)
        code_q <= code_d;
    end
  end

  assign key_col     = key_col_q;
  assign key_map     = map_w;
  assign key_code    = code_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_multi   = multi_q;

endmodule

// File: tb/tb_keypad_scan_gen.sv
// Directed bench for keypad_scan_gen with a keypad model
// and an event scoreboard for press/release pulses.
module tb_keypad_scan_gen;

  localparam int NC = 4;
  localparam int NR = 5;
  localparam int SD = 4;
  localparam int DB = 2;
  localparam int NK = NC * NR;
  localparam int FR = NC * SD;

  localparam logic [1:0] EV_PRESS   = 2'b10;
  localparam logic [1:0] EV_RELEASE = 2'b01;

  typedef struct {
    logic [1:0] kind;
    logic [4:0] code;
    int         due;
  } evt_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NR-1:0] key_row;
  logic [NC-1:0] key_col;
  logic [NK-1:0] key_map;
  logic [4:0]    key_code;
  logic          key_press, key_release, key_multi;

  logic [NK-1:0] keys = '0;
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  evt_t          evq[$];

  keypad_scan_gen #(
    .N_COL(NC), .N_ROW(NR), .SCAN_DIV(SD), .DEBOUNCE(DB)
  ) dut (
    .clk(clk), .rstn(rstn), .key_row(key_row),
    .key_col(key_col), .key_map(key_map),
    .key_code(key_code), .key_press(key_press),
    .key_release(key_release), .key_multi(key_multi)
  );

  always #5 clk = ~clk;

  always_comb begin
    key_row = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (keys[c*NR+r] && !key_col[c]) key_row[r] = 1'b0;
  end

  always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s cyc=%0d observed=%0h expected=%0h",
               tag, cyc, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic expect_evt(input logic [1:0] k,
                            input int code, input int due);
    evt_t e;
    e.kind = k;
    e.code = 5'(code);
    e.due  = due;
    evq.push_back(e);
  endtask

  task automatic goto(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < t) check("goto_timeout", cyc, t);
  endtask

  // commit visible frame-end+2, pulse at frame-end+3
  function automatic int pulse_cyc(input int f);
    return FR * f + FR + 3;
  endfunction

  function automatic int frame_start(input int f);
    return FR * f + 1;
  endfunction

  always @(negedge clk) begin
    logic [NC-1:0] exp_col;
    evt_t e;
    if (!rstn || cyc == 0)
      exp_col = '1;
    else
      exp_col = ~(NC'(1) << (((cyc - 1) / SD) % NC));
    check("key_col", 32'(key_col), 32'(exp_col));
    if (!rstn) begin
      check("rst_outs",
            {key_map, key_code, key_press, key_release, key_multi},
            '0);
    end else if (key_press || key_release) begin
      if (evq.size() == 0) begin
        check("spurious_pulse", {key_press, key_release}, 2'b00);
      end else begin
        e = evq.pop_front();
        check("evt_kind", {key_press, key_release}, e.kind);
        check("evt_code", key_code, e.code);
        check("evt_cyc", cyc, e.due);
      end
    end else if (evq.size() != 0 && cyc > evq[0].due) begin
      e = evq.pop_front();
      check("evt_missing", {key_press, key_release}, e.kind);
    end
  end

  initial begin
    // 1: reset, idle keypad
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("idle_col", key_col, 4'hF);
    goto(FR * 3);
    check("idle_map", key_map, 0);
    check("idle_multi", key_multi, 1'b0);

    // 2: key 11 (col 2, row 1) over frames 3 and 4
    goto(frame_start(3));
    keys = NK'(1) << 11;
    expect_evt(EV_PRESS, 11, pulse_cyc(4));
    goto(frame_start(5));
    keys = '0;
    goto(pulse_cyc(4) - 1);
    check("map_k11", key_map, 32'(NK'(1) << 11));
    goto(pulse_cyc(4) + 1);
    check("multi_k11", key_multi, 1'b0);

    // 3: idle frames 5 and 6 release it
    expect_evt(EV_RELEASE, 11, pulse_cyc(6));
    goto(pulse_cyc(6) + 2);
    check("map_rel", key_map, 0);
    check("code_hold", key_code, 11);

    // 4: key 7 bounces: in 8, out 9, in 10 and 11
    goto(frame_start(8));
    keys = NK'(1) << 7;
    goto(frame_start(9));
    keys = '0;
    goto(frame_start(10));
    keys = NK'(1) << 7;
    expect_evt(EV_PRESS, 7, pulse_cyc(11));
    goto(frame_start(12));
    keys = '0;
    goto(pulse_cyc(11) - 1);
    check("map_k7", key_map, 32'(NK'(1) << 7));
    expect_evt(EV_RELEASE, 7, pulse_cyc(13));

    // 5: keys 0 and 19 together in frames 15 and 16
    goto(frame_start(15));
    keys = (NK'(1) << 19) | NK'(1);
    goto(frame_start(17));
    keys = '0;
    goto(pulse_cyc(16) + 1);
    check("map_2k", key_map, 32'h80001);
    check("multi_2k", key_multi, 1'b1);
    expect_evt(EV_RELEASE, 7, pulse_cyc(18));
    goto(pulse_cyc(18) + 1);
    check("multi_clr", key_multi, 1'b0);

    // 6: key 11 held, reset pulsed mid-frame
    goto(frame_start(19));
    keys = NK'(1) << 11;
    expect_evt(EV_PRESS, 11, pulse_cyc(20));
    goto(FR * 21 + 6);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_col", key_col, 4'hF);
    check("rst_map", key_map, 0);
    check("rst_code", key_code, 0);
    check("rst_flags", {key_press, key_release, key_multi}, 3'b000);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    expect_evt(EV_PRESS, 11, pulse_cyc(1));
    goto(frame_start(2));
    keys = '0;
    expect_evt(EV_RELEASE, 11, pulse_cyc(3));
    goto(pulse_cyc(3) + 10);
    check("evq_empty", evq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
